wr_skew_control: RTL and testbench

//   Parametrised write-side address/enable sequencer for the systolic array output memory.

---
 rtl/wr_skew_control.sv | 133 +++++++++++++
 tb/tb_wr_skew_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_skew_control.sv
// Skewed write-wavefront sequencer for the systolic array output memory.
// Column c writes num_rows consecutive addresses from base, starting c cycles after column 0.
module wr_skew_control #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           num_rows,
    input  logic                      stall,
    input  logic                      sys_arr_active,
    output logic [WIDTH-1:0]          wr_en,
    output logic [WIDTH*ADDR_W-1:0]   wr_addr,
    output logic                      busy,
    output logic                      done
);

    localparam int KW = ADDR_W + 1 + $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [ADDR_W:0]           rows_q, rows_d;
    logic [WIDTH-1:0]          en_q, en_d;
    logic [WIDTH*ADDR_W-1:0]   addr_q, addr_d;
    logic                      done_q, done_d;

    logic                      step;
    logic                      last;
    logic [KW-1:0]             k_n;
    logic [KW-1:0]             rel;
    logic [ADDR_W-1:0]         b_n;
    logic [ADDR_W:0]           r_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            rows_q  <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign last = (k_q == KW'(rows_q) + KW'(WIDTH - 2));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        rows_d  = rows_q;
        en_d    = en_q;
        addr_d  = addr_q;
        done_d  = done_q;
        step    = 1'b0;
        k_n     = '0;
        rel     = '0;
        b_n     = base_q;
        r_n     = rows_q;

        if (sys_arr_active) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        state_d = S_RUN;
                        base_d  = base_addr;
                        rows_d  = num_rows;
                        k_d     = '0;
                        done_d  = 1'b0;
                        step    = 1'b1;
                        b_n     = base_addr;
                        r_n     = num_rows;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (last) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        en_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        k_d  = k_q + 1'b1;
                        k_n  = k_q + 1'b1;
                        step = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Precompute the enables/addresses that the next cycle (k_n) presents.
        if (step) begin
            for (int c = 0; c < WIDTH; c++) begin
                rel     = k_n - KW'(c);
                en_d[c] = (k_n >= KW'(c)) && (rel < KW'(r_n));
                if (en_d[c]) begin
                    addr_d[c*ADDR_W +: ADDR_W] = b_n + rel[ADDR_W-1:0];
                end
            end
        end
    end

    assign wr_en   = en_q & ~{WIDTH{stall}};
    assign wr_addr = addr_q;
    assign busy    = (state_q == S_RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_wr_skew_control.sv
// Directed bench for wr_skew_control with WIDTH=4, ADDR_W=8.
// Hand-written enable tables plus a per-cycle lane model for addresses.
module tb_wr_skew_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_rows;
    logic        stall;
    logic        sys_arr_active;
    logic [3:0]  wr_en;
    logic [31:0] wr_addr;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [3:0] en_log [0:15];

    wr_skew_control #(.WIDTH(4), .ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_rows       (num_rows),
        .stall          (stall),
        .sys_arr_active (sys_arr_active),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        start          = 1'b0;
        sys_arr_active = 1'b0;
        stall          = 1'b0;
    endtask

    // One pass: optional stall burst at run index st_at, optional
    // start+sys_arr_active on the final run cycle.
    task automatic run_pass(input logic [7:0] b, input logic [8:0] r,
                            input int st_at, input int st_len,
                            input logic last_poke);
        int k;
        int stalled;
        int writes;
        int nrun;
        logic [3:0] ee;
        logic [7:0] ea;
        nrun    = int'(r) + 3;
        k       = 0;
        stalled = 0;
        writes  = 0;
        start     = 1'b1;
        base_addr = b;
        num_rows  = r;
        next_cyc();
        while (k < nrun) begin
            if (k == st_at && stalled < st_len) begin
                stall     = 1'b1;
                start     = 1'b1;
                base_addr = ~b;
                #1;
                check("stall_en", 32'(wr_en), 32'h0);
                check("stall_busy", 32'(busy), 32'h1);
                stalled++;
            end else begin
                base_addr = b;
                if (last_poke && k == nrun - 1) begin
                    start          = 1'b1;
                    sys_arr_active = 1'b1;
                end
                #1;
                ee = '0;
                for (int c = 0; c < 4; c++) begin
                    ee[c] = (k >= c) && (k < c + int'(r));
                end
                check("run_en", 32'(wr_en), 32'(ee));
                check("run_busy", 32'(busy), 32'h1);
                for (int c = 0; c < 4; c++) begin
                    if (ee[c]) begin
                        ea = b + 8'(k - c);
                        check("lane_addr", 32'(wr_addr[c*8 +: 8]), 32'(ea));
                        writes++;
                    end
                end
                if (k < 16) en_log[k] = wr_en;
                k++;
            end
            next_cyc();
        end
        check("end_busy", 32'(busy), 32'h0);
        check("end_done", 32'(done), 32'h1);
        check("end_en", 32'(wr_en), 32'h0);
        check("writes", 32'(writes), 32'(4 * int'(r)));
    endtask

    logic [3:0] tab1 [0:6];
    logic [3:0] tab2 [0:3];

    initial begin
        tab1 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        tab2 = '{4'h1, 4'h2, 4'h4, 4'h8};
        reset          = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        num_rows       = '0;
        stall          = 1'b0;
        sys_arr_active = 1'b0;
        #12;
        check("rst_en", 32'(wr_en), 32'h0);
        check("rst_addr", wr_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        next_cyc();

        // basic pass
        run_pass(8'h00, 9'd4, -1, 0, 1'b0);
        for (int i = 0; i < 7; i++) check("tab4", 32'(en_log[i]), 32'(tab1[i]));
        check("lanes_last", wr_addr, 32'h03030303);

        sys_arr_active = 1'b1;
        next_cyc();
        check("saa_clear", 32'(done), 32'h0);

        // single row, completion coincides with start and sys_arr_active
        run_pass(8'h05, 9'd1, -1, 0, 1'b1);
        for (int i = 0; i < 4; i++) check("tab1row", 32'(en_log[i]), 32'(tab2[i]));
        check("lanes5", wr_addr, 32'h05050505);
        next_cyc();
        check("ignored_start", 32'(busy), 32'h0);
        check("done_held", 32'(done), 32'h1);

        // address wrap
        run_pass(8'hFE, 9'd4, -1, 0, 1'b0);
        check("wrap_last", wr_addr, 32'h01010101);

        // stall burst at k=2 with start pokes during it
        run_pass(8'h00, 9'd4, 2, 3, 1'b0);
        for (int i = 0; i < 7; i++) check("stall_tab", 32'(en_log[i]), 32'(tab1[i]));

        // rows=0 start
        sys_arr_active = 1'b1;
        next_cyc();
        check("clr_before_r0", 32'(done), 32'h0);
        start    = 1'b1;
        num_rows = 9'd0;
        next_cyc();
        check("r0_done", 32'(done), 32'h1);
        check("r0_busy", 32'(busy), 32'h0);
        check("r0_en", 32'(wr_en), 32'h0);
        next_cyc();
        check("r0_idle", 32'(busy), 32'h0);

        // async reset mid-pass at k=3
        start     = 1'b1;
        base_addr = 8'h20;
        num_rows  = 9'd4;
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc();
        check("pre_rst_en", 32'(wr_en), 32'hF);
        #2;
        reset = 1'b1;
        #1;
        check("arst_en", 32'(wr_en), 32'h0);
        check("arst_addr", wr_addr, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        next_cyc();
        reset = 1'b0;
        next_cyc();
        check("post_rst_idle", 32'(busy), 32'h0);
        run_pass(8'h03, 9'd2, -1, 0, 1'b0);
        check("post_rst_addr", wr_addr, 32'h04040404);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
